// File: rtl/edge_event_scheduler.sv
// Timestamps per-channel rising/falling edge pulses, holds them pending and
// serialises them onto one valid/ready event stream via round-robin arbitration.
module edge_event_scheduler #(
  parameter int NCH  = 4,
  parameter int TS_W = 16,
  localparam int CW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic [NCH-1:0]  pose_edge,
  input  logic [NCH-1:0]  neg_edge,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [CW-1:0]   evt_ch,
  output logic            evt_rise,
  output logic [TS_W-1:0] evt_ts,
  input  logic            clr_ovf,
  output logic [NCH-1:0]  overflow
);

  localparam int NS = 2 * NCH;
  localparam int SW = $clog2(NS);

  logic [TS_W-1:0] cnt;
  logic [NS-1:0]   pending;
  logic [NS-1:0]   src;
  logic [TS_W-1:0] ts [NS];
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   win;
  logic            win_found;
  logic            load;
  logic            grant;
  logic [NCH-1:0]  ovf_set;

  // Even source index is the rising edge of a channel, odd is the falling edge.
  always_comb begin
    src = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      src[2*ch]   = enable & pose_edge[ch];
      src[2*ch+1] = enable & neg_edge[ch];
    end
  end

  always_comb begin
    int idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NS) idx = idx - NS;
      if (!win_found && pending[SW'(idx)]) begin
        win_found = 1'b1;
        win       = SW'(idx);
      end
    end
  end

  assign load  = !evt_valid || evt_ready;
  assign grant = load && win_found;

  // A pulse is lost only when its source is still pending and not being drained now.
  always_comb begin
    ovf_set = '0;
    for (int s = 0; s < NS; s++) begin
      if (src[s] && pending[s] && !(grant && win == SW'(s)))
        ovf_set[s/2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      pending   <= '0;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      evt_ts    <= '0;
      overflow  <= '0;
    end else begin
      if (enable) cnt <= cnt + 1'b1;

      if (load) begin
        if (win_found) begin
          evt_valid <= 1'b1;
          evt_ch    <= CW'(win >> 1);
          evt_rise  <= ~win[0];
          evt_ts    <= ts[win];
          ptr       <= (win == SW'(NS - 1)) ? '0 : win + 1'b1;
        end else begin
          evt_valid <= 1'b0;
        end
      end

      for (int s = 0; s < NS; s++) begin
        if (grant && win == SW'(s))
          pending[s] <= src[s];
        else if (src[s])
          pending[s] <= 1'b1;
      end

      overflow <= (clr_ovf ? '0 : overflow) | ovf_set;
    end
  end

  // Timestamps need no reset: a stale value is never visible without its pending bit.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (src[s] && (!pending[s] || (grant && win == SW'(s))))
        ts[s] <= cnt;
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: expected events go into a queue
// when stimulus is issued and a monitor compares them at each transfer.
module tb_edge_event_scheduler;

  localparam int NCH  = 4;
  localparam int TS_W = 8;

  typedef struct packed {
    logic [1:0] ch;
    logic       rise;
    logic [7:0] ts;
  } evt_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            enable = 1'b0;
  logic [NCH-1:0]  pose_edge = '0;
  logic [NCH-1:0]  neg_edge = '0;
  logic            evt_ready = 1'b0;
  logic            clr_ovf = 1'b0;
  logic            evt_valid;
  logic [1:0]      evt_ch;
  logic            evt_rise;
  logic [TS_W-1:0] evt_ts;
  logic [NCH-1:0]  overflow;

  evt_t       exp_q[$];
  evt_t       got;
  evt_t       want;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cnt_m = '0;
  logic [7:0] c;

  edge_event_scheduler #(.NCH(NCH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .pose_edge(pose_edge),
    .neg_edge (neg_edge),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_ch   (evt_ch),
    .evt_rise (evt_rise),
    .evt_ts   (evt_ts),
    .clr_ovf  (clr_ovf),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushEvt(input int ch, input logic rise, input logic [7:0] ts);
    exp_q.push_back({2'(ch), rise, ts});
  endtask

  // Inputs change 1 time unit after the edge; the counter model follows enable.
  task automatic applyStimulus(input logic [3:0] pe, input logic [3:0] ne,
                               input logic en, input logic rdy, input logic clr);
    pose_edge = pe;
    neg_edge  = ne;
    enable    = en;
    evt_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    if (en) cnt_m = cnt_m + 8'd1;
    #1;
  endtask

  task automatic idle(input int n, input logic en, input logic rdy);
    repeat (n) applyStimulus(4'h0, 4'h0, en, rdy, 1'b0);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic doReset(input string tag);
    pose_edge = '0;
    neg_edge  = '0;
    clr_ovf   = 1'b0;
    #1 resetn = 1'b0;
    #1;
    checkOutput({tag, "_rst_valid"}, 32'(evt_valid), 32'd0);
    checkOutput({tag, "_rst_ch"}, 32'(evt_ch), 32'd0);
    checkOutput({tag, "_rst_rise"}, 32'(evt_rise), 32'd0);
    checkOutput({tag, "_rst_ts"}, 32'(evt_ts), 32'd0);
    checkOutput({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
    #1 resetn = 1'b1;
    cnt_m = '0;
  endtask

  // Monitor: every accepted transfer must match the oldest expected event.
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      got = {evt_ch, evt_rise, evt_ts};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event: got ch=%0d rise=%0d ts=%0d expected none",
                 evt_ch, evt_rise, evt_ts);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("[TB] FAIL event: got ch=%0d rise=%0d ts=%0d expected ch=%0d rise=%0d ts=%0d",
                   evt_ch, evt_rise, evt_ts, want.ch, want.rise, want.ts);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_valid", 32'(evt_valid), 32'd0);
    checkOutput("init_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;

    // Single pulse with counter at 5, two-clock latency, one-cycle event.
    idle(5, 1'b1, 1'b1);
    pushEvt(2, 1'b1, 8'd5);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_valid_e0", 32'(evt_valid), 32'd0);
    idle(1, 1'b1, 1'b1);
    checkOutput("t1_valid_e1", 32'(evt_valid), 32'd1);
    idle(1, 1'b1, 1'b1);
    checkOutput("t1_valid_e2", 32'(evt_valid), 32'd0);

    // Pointer now sits at source 5, so ch3 rise (source 6) beats ch0 rise.
    c = cnt_m;
    pushEvt(3, 1'b1, c);
    pushEvt(0, 1'b1, c);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Three simultaneous pulses after reset, delivered back to back.
    doReset("t2");
    pushEvt(0, 1'b1, 8'd0);
    pushEvt(1, 1'b0, 8'd0);
    pushEvt(3, 1'b1, 8'd0);
    applyStimulus(4'b1001, 4'b0010, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1, 1'b1);
      checkOutput($sformatf("t2_valid_%0d", i), 32'(evt_valid), 32'd1);
    end
    idle(1, 1'b1, 1'b1);
    checkOutput("t2_valid_end", 32'(evt_valid), 32'd0);

    // Backpressure: ch0 rise occupies the output, ch1 fall pulses twice.
    c = cnt_m;
    pushEvt(0, 1'b1, c);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    c = cnt_m;
    pushEvt(1, 1'b0, c);
    applyStimulus(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0);
    checkOutput("t3_ovf_before", 32'(overflow), 32'd0);
    applyStimulus(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_ovf_set", 32'(overflow), 32'h2);
    checkOutput("t3_hold_valid", 32'(evt_valid), 32'd1);
    checkOutput("t3_hold_ch", 32'(evt_ch), 32'd0);
    checkOutput("t3_hold_rise", 32'(evt_rise), 32'd1);
    idle(4, 1'b1, 1'b1);
    checkOutput("t3_drained", 32'(evt_valid), 32'd0);
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_ovf_clr", 32'(overflow), 32'd0);

    // Fairness: every source pulses for 16 cycles; grants rotate 0..7.
    doReset("t4");
    for (int k = 1; k <= 23; k++)
      pushEvt(((k - 1) % 8) / 2, ((k - 1) % 2) == 0, 8'((k > 8) ? (k - 8) : 0));
    repeat (16) applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_ovf_all", 32'(overflow), 32'hF);
    idle(10, 1'b1, 1'b1);
    checkOutput("t4_drained", 32'(evt_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);

    // Counter wrap: capture at 255, then at 0 on the following cycle.
    doReset("t5");
    idle(255, 1'b1, 1'b1);
    pushEvt(2, 1'b0, 8'd255);
    applyStimulus(4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0);
    pushEvt(1, 1'b1, 8'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);

    // Disabled: pulses ignored, pending drains, counter holds.
    c = cnt_m;
    pushEvt(0, 1'b0, c);
    applyStimulus(4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    pushEvt(3, 1'b1, c + 8'd1);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);

    // Reset while stalled with an event held and sources pending.
    c = cnt_m;
    applyStimulus(4'b1010, 4'b1100, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_pre_valid", 32'(evt_valid), 32'd1);
    checkOutput("t6_pre_ch", 32'(evt_ch), 32'd3);
    checkOutput("t6_pre_rise", 32'(evt_rise), 32'd0);
    checkOutput("t6_pre_ts", 32'(evt_ts), 32'(c));
    checkOutput("t6_pre_ovf", 32'(overflow), 32'h2);
    doReset("t6");
    idle(10, 1'b1, 1'b1);
    checkOutput("t6_no_stale", 32'(evt_valid), 32'd0);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Collects single-cycle rising/falling edge pulses from NCH per-channel edge detectors, timestamps each pulse, holds it pending, and serialises all pending events onto one valid/ready event stream through a round-robin arbiter. It sits between the bank of edge detectors and the shared downstream consumer, such as a logger, FIFO or CPU port. That consumer can accept only one event per clock and may stall.

## Interface
- NCH, 4: number of input channels (2..16).
- TS_W, 16: timestamp counter width (4..32).
- CW, $clog2(NCH): channel-index width (derived, not overridable).

- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- enable  input  1  1 = counter runs and pulses are accepted; 0 = counter holds and pulses are ignored.
- pose_edge  input  NCH  rising-edge pulses, one bit per channel, one clk wide.
- neg_edge  input  NCH  falling-edge pulses, one bit per channel, one clk wide.
- evt_ready  input  1  consumer accepts the event when high with evt_valid.
- evt_valid  output  1  output event register holds an event.
- evt_ch  output  CW  channel index of the event.
- evt_rise  output  1  1 = rising edge, 0 = falling edge.
- evt_ts  output  TS_W  timestamp captured when the pulse was sampled.
- clr_ovf  input  1  clears all overflow flags.
- overflow  output  NCH  sticky per-channel lost-event flag.

## Operation
- **Sources:** there are 2*NCH sources. Source s = 2*ch is rising and s = 2*ch+1 is falling. Each source has one pending bit and one TS_W timestamp register.
- **Timestamp counter:** free-running. It increments by 1 per clk while enable=1, holds while enable=0, and wraps from 2^TS_W-1 to 0 with no flag.
- **Capture:** a pulse sampled with enable=1 and pending[s]=0 sets pending[s]. ts[s] takes the counter value present in that cycle, before the increment.
- **Overflow:** a pulse on source s while pending[s]=1 and s is not granted this cycle sets overflow[ch]. The new pulse is dropped and the oldest ts[s] is kept.
- **Grant same cycle as new pulse:** if a pulse on s arrives in the cycle s is granted, pending[s] stays 1 with the new timestamp. No overflow is flagged.
- **Output register load condition:** load when evt_valid=0, or when evt_valid=1 and evt_ready=1, and at least one pending bit is set.
- **Arbitration:** round-robin. Search starts at ptr and goes upward, wrapping modulo 2*NCH.
- **Winner handling:** the winner w loads {evt_ch=w>>1, evt_rise=~w[0], evt_ts=ts[w]} and sets evt_valid=1. pending[w] clears and ptr becomes (w+1) mod 2*NCH.
- **Drain with nothing pending:** if the load condition holds but nothing is pending, then evt_valid is 0 after the edge. ptr is unchanged.
- **Stall hold:** while evt_valid=1 and evt_ready=0, the evt_* outputs are stable.
- **Pending while disabled:** with enable=0, pending events still drain normally.
- **Overflow clear:** clr_ovf=1 clears all overflow bits. If a new overflow occurs in the same cycle, the set wins for that channel.
- **Reset (asynchronous, resetn=0):** evt_valid=0, evt_ch=0, evt_rise=0, evt_ts=0, overflow=0. All pending=0, ptr=0, counter=0. Reset mid-operation discards held and pending events.

## Timing
- **Latency:** a pulse sampled at edge E0 sets pending at E0. With the output free, evt_valid rises after E1, so latency is 2 clocks from the pulse cycle to the first valid cycle.
- **Throughput:** with evt_ready held high, one event per clock.
- **Transfer:** occurs on an edge where evt_valid=1 and evt_ready=1. The next event can be valid in the following cycle with no bubble.
- **Backpressure:** evt_ready may be low indefinitely. Pending state keeps accumulating.
- **Overflow visibility:** overflow updates at the edge that samples the offending pulse and is visible the next cycle.
- **Combinational paths:** there is no combinational path from inputs to outputs. All outputs are registered.

## Test plan
Use NCH=4, TS_W=8.

1. Single pulse: with counter=5 and evt_ready=1, pulse pose_edge[2] for one clock. Two clocks later expect evt_valid=1, evt_ch=2, evt_rise=1, evt_ts=5 for exactly 1 cycle, then ptr=5.
2. Simultaneous pulses after reset: pulse pose_edge[0], neg_edge[1] and pose_edge[3] in the same cycle with ready=1. Expect three back-to-back events (ch0 rise, ch1 fall, ch3 rise), all with the same ts, then evt_valid=0.
3. Backpressure and overflow: hold evt_ready=0 and send two neg_edge[1] pulses 3 clocks apart. Expect overflow[1]=1 and the first event's ts kept.
   - Then set ready=1: exactly one ch1 fall event is delivered.
   - Then pulse clr_ovf: overflow[1]=0.
4. Fairness: hold all 8 sources pulsing every cycle with ready=1. Expect the grant order 0,1,...,7,0,... with no source starved for more than 8 cycles.
5. Wrap and enable: let the counter pass 255 and check the next captured ts is 0.
   - Then drive enable=0 and pulse pose_edge[0]: no event, and the counter holds.
6. Reset mid-stall: with evt_valid=1, ready=0 and 3 sources pending, assert resetn=0 asynchronously between edges. All outputs go to 0 immediately.
   - After release, no stale events appear.
